dif_butterfly: RTL

- Gentleman-Sande (decimation-in-frequency) butterfly for the inverse NTT datapath; the counterpart of the Cooley-Tukey DIT butterfly used by the forward NTT.
- Computes A' = (A + B) mod q and B' = ((A - B) * W) mod q.
- Fully pipelined, one operation accepted per clock, valid flag travelling with the data.
- Mode 1 reuses the multiplier for plain modular multiplication (twiddle/point-wise products).

---
 rtl/dif_butterfly_pkg.sv | 24 ++
 rtl/mod_mul_pipe.sv | 45 ++++
 rtl/dif_butterfly.sv | 109 ++++++++++
 3 files changed

// File: rtl/dif_butterfly_pkg.sv
// Shared constants for the NTT butterflies: pipeline depths, total latency, mode codes.
// DIF_HALVE_EN adds the output halving stage to the derived latency.
`ifndef INTMUL_DELAY
`define INTMUL_DELAY 3
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 2
`endif

package dif_butterfly_pkg;
  localparam int MUL_LAT = `INTMUL_DELAY;
  localparam int RED_LAT = `MODRED_DELAY;
`ifdef DIF_HALVE_EN
  localparam int HALVE_LAT = 1;
`else
  localparam int HALVE_LAT = 0;
`endif
  localparam int BFLY_LAT = 1 + MUL_LAT + RED_LAT + HALVE_LAT;

  typedef enum logic {
    MODE_BFLY = 1'b0,
    MODE_MUL  = 1'b1
  } mode_e;
endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined (a*b) mod q: MUL_LAT product stages then RED_LAT reduction stages.
// Shared between the DIT and DIF butterflies; q travels with the product.
module mod_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = dif_butterfly_pkg::MUL_LAT,
  parameter int RED_LAT = dif_butterfly_pkg::RED_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] p_o
);
  logic [MUL_LAT-1:0][2*WIDTH-1:0] prod_q;
  logic [MUL_LAT-1:0][WIDTH-1:0]   qm_q;
  logic [RED_LAT-1:0][WIDTH-1:0]   red_q;
  logic [WIDTH-1:0]                rem_d;

  // q is zero only in the reset-flushed slots; keep those outputs at 0 instead of X
  always_comb begin
    rem_d = '0;
    if (qm_q[MUL_LAT-1] != '0)
      rem_d = WIDTH'(prod_q[MUL_LAT-1] % {{WIDTH{1'b0}}, qm_q[MUL_LAT-1]});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_q <= '0;
      qm_q   <= '0;
      red_q  <= '0;
    end else begin
      prod_q[0] <= {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
      qm_q[0]   <= q_i;
      for (int i = 1; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        qm_q[i]   <= qm_q[i-1];
      end
      red_q[0] <= rem_d;
      for (int i = 1; i < RED_LAT; i++) red_q[i] <= red_q[i-1];
    end
  end

  assign p_o = red_q[RED_LAT-1];
endmodule

// File: rtl/dif_butterfly.sv
// Gentleman-Sande butterfly: A'=(A+B) mod q, B'=((A-B)*W) mod q; mode 1 is plain A*W mod q.
// DIF_HALVE_EN appends a registered stage that scales mode-0 results by 2^-1 mod q.
module dif_butterfly #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = dif_butterfly_pkg::MUL_LAT,
  parameter int RED_LAT = dif_butterfly_pkg::RED_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             valid_out
);
  localparam int LAT = 1 + MUL_LAT + RED_LAT;
`ifdef DIF_HALVE_EN
  localparam int QD = LAT;
`else
  localparam int QD = 1;
`endif

  logic [LAT:1]            vld_pipe, mode_pipe;
  logic [LAT:1][WIDTH-1:0] s_pipe;
  logic [QD:1][WIDTH-1:0]  q_pipe;
  logic [WIDTH-1:0]        d0_q, w0_q;
  logic [WIDTH:0]          sum_w;
  logic [WIDTH-1:0]        s_d, d_d, prod, a_res, b_res;

  always_comb begin
    sum_w = {1'b0, A} + {1'b0, B};
    s_d   = sum_w[WIDTH-1:0];
    if (sum_w >= {1'b0, modulus}) s_d = WIDTH'(sum_w - {1'b0, modulus});
    d_d = A - B;
    if (A < B) d_d = A - B + modulus;
    if (mode == dif_butterfly_pkg::MODE_MUL) d_d = A;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe  <= '0;
      mode_pipe <= '0;
      s_pipe    <= '0;
      q_pipe    <= '0;
      d0_q      <= '0;
      w0_q      <= '0;
    end else begin
      vld_pipe[1]  <= valid_in;
      mode_pipe[1] <= mode;
      s_pipe[1]    <= s_d;
      q_pipe[1]    <= modulus;
      d0_q         <= d_d;
      w0_q         <= W;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        mode_pipe[i] <= mode_pipe[i-1];
        s_pipe[i]    <= s_pipe[i-1];
      end
      for (int i = 2; i <= QD; i++) q_pipe[i] <= q_pipe[i-1];
    end
  end

  mod_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .RED_LAT(RED_LAT)) u_mm (
    .clk   (clk),
    .reset (reset),
    .a_i   (d0_q),
    .b_i   (w0_q),
    .q_i   (q_pipe[1]),
    .p_o   (prod)
  );

  assign a_res = (mode_pipe[LAT] == dif_butterfly_pkg::MODE_MUL) ? prod : s_pipe[LAT];
  assign b_res = (mode_pipe[LAT] == dif_butterfly_pkg::MODE_MUL) ? '0 : prod;

`ifdef DIF_HALVE_EN
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] q);
    logic [WIDTH:0] t;
    t = {1'b0, x} + (x[0] ? {1'b0, q} : '0);
    return t[WIDTH:1];
  endfunction

  logic [WIDTH-1:0] a_out_q, b_out_q;
  logic             vld_out_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_out_q   <= '0;
      b_out_q   <= '0;
      vld_out_q <= 1'b0;
    end else begin
      vld_out_q <= vld_pipe[LAT];
      a_out_q   <= mode_pipe[LAT] ? a_res : halve(a_res, q_pipe[LAT]);
      b_out_q   <= mode_pipe[LAT] ? b_res : halve(b_res, q_pipe[LAT]);
    end
  end

  assign A_out     = a_out_q;
  assign B_out     = b_out_q;
  assign valid_out = vld_out_q;
`else
  assign A_out     = a_res;
  assign B_out     = b_res;
  assign valid_out = vld_pipe[LAT];
`endif
endmodule
